// File: rtl/rank_pkg.sv
// +--------------------------------------------------------------------+
// | rank_pkg: shared state encoding and rank-width helper.              |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package rank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int rank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rank_order_check.sv
// +--------------------------------------------------------------------+
// | rank_order_check: flags a beat scoring higher than the one before.  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module rank_order_check #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  fire,
    input  logic                  first,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  order_err
);

    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= '0;
            r_err  <= 1'b0;
        end else begin
            if (clear) begin
                r_err <= 1'b0;
            end else if (fire && !first && (data > r_prev)) begin
                r_err <= 1'b1;
            end
            if (fire) begin
                r_prev <= data;
            end
        end
    end

    assign order_err = r_err;

endmodule

`default_nettype wire

// File: rtl/top10_stream.sv
// +--------------------------------------------------------------------+
// | top10_stream: streams a captured top-N result set one rank per beat.|
// | Optional order checker under RANK_CHECK_EN.  Revision: 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

module top10_stream
    import rank_pkg::*;
#(
    parameter  int DATA_WIDTH = 4,
    parameter  int TOP_N      = 10,
    parameter  int ID_WIDTH   = 6,
    localparam int RANK_W     = rank_w(TOP_N)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic [DATA_WIDTH*TOP_N-1:0]    array_in,
    input  logic [ID_WIDTH*TOP_N-1:0]      id_in,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [ID_WIDTH-1:0]            out_id,
    output logic [RANK_W-1:0]              out_rank,
    output logic                           out_last,
`ifdef RANK_CHECK_EN
    output logic                           done,
    output logic                           order_err
`else
    output logic                           done
`endif
);

    localparam logic [RANK_W-1:0] C_LAST_IDX = RANK_W'(TOP_N - 1);

    state_t                        r_state;
    state_t                        w_next;
    logic [DATA_WIDTH*TOP_N-1:0]   r_vals;
    logic [ID_WIDTH*TOP_N-1:0]     r_ids;
    logic [RANK_W-1:0]             r_idx;
    logic                          w_fire;
    logic                          w_at_last;
    logic                          w_accept;

    assign w_fire    = out_valid & out_ready;
    assign w_at_last = (r_idx == C_LAST_IDX);
    assign w_accept  = (r_state == IDLE) & load;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_next = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (w_fire && w_at_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Shadow copy is only rewritten on an accepted load, so the sorter may move on.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vals <= '0;
            r_ids  <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_vals <= array_in;
            r_ids  <= id_in;
            r_idx  <= '0;
        end else if (w_fire && !w_at_last) begin
            r_idx  <= r_idx + RANK_W'(1);
        end
    end

    assign out_data = out_valid ? r_vals[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign out_id   = out_valid ? r_ids[int'(r_idx)*ID_WIDTH +: ID_WIDTH]      : '0;
    assign out_rank = out_valid ? r_idx : '0;
    assign out_last = out_valid & w_at_last;

`ifdef RANK_CHECK_EN
    rank_order_check #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_order_check (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_accept),
        .fire      (w_fire),
        .first     (r_idx == '0),
        .data      (out_data),
        .order_err (order_err)
    );
`endif

endmodule

`default_nettype wire
